// File: rtl/fetch_prefetch.sv
// Instruction-fetch stage: PC generation, prefetch queue and valid/ready handoff to decode.
// Optional FETCH_MISALIGN_EN: a misaligned redirect target becomes one fault entry and halts fetch.
module fetch_prefetch #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            re_o,
    output logic [XLEN-1:0] addr_o,
    input  logic [XLEN-1:0] instr_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            instr_valid_o,
    input  logic            instr_ready_i,
    output logic [XLEN-1:0] instr_o,
    output logic [XLEN-1:0] pc_o
`ifdef FETCH_MISALIGN_EN
    ,
    output logic            fault_o
`endif
);

    // state    | meaning
    // ST_RUN   | sequential fetch, issue whenever the queue has room
    // ST_FAULT | misaligned redirect seen, fault entry is pushed this cycle
    // ST_HALT  | no reads issued until the next redirect or reset
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FAULT = 2'd1,
        ST_HALT  = 2'd2
    } state_e;

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned OW = CW + 1;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic              inflight_q, inflight_d;
    logic [XLEN-1:0]   inflight_pc_q, inflight_pc_d;
    logic [PW-1:0]     head_q, head_d;
    logic [PW-1:0]     tail_q, tail_d;
    logic [CW-1:0]     count_q, count_d;

    logic [XLEN-1:0]   q_pc_q    [DEPTH];
    logic [XLEN-1:0]   q_instr_q [DEPTH];

    logic [XLEN-1:0]   redir_tgt;
    logic              redir_misalign;
    logic              head_valid;
    logic              pop;
    logic              push;
    logic [XLEN-1:0]   push_pc;
    logic [XLEN-1:0]   push_instr;
    logic [OW-1:0]     occ;

`ifdef FETCH_MISALIGN_EN
    logic              q_fault_q [DEPTH];
    logic [XLEN-1:0]   fault_pc_q, fault_pc_d;
    logic              push_fault;

    always_comb begin
        redir_tgt      = redirect_pc_i;
        redir_misalign = |redirect_pc_i[1:0];
    end
`else
    always_comb begin
        redir_tgt      = redirect_pc_i & ~XLEN'(3);
        redir_misalign = 1'b0;
    end
`endif

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        head_d        = head_q;
        tail_d        = tail_q;
        count_d       = count_q;
        push          = 1'b0;
        push_pc       = inflight_pc_q;
        push_instr    = instr_i;
`ifdef FETCH_MISALIGN_EN
        fault_pc_d    = fault_pc_q;
        push_fault    = 1'b0;
`endif
        re_o          = 1'b0;
        addr_o        = '0;
        head_valid    = (count_q != '0) && !rst;
        instr_valid_o = head_valid && !redirect_i;
        pop           = instr_valid_o && instr_ready_i;
        // Occupancy counts the word still in flight so a push can never overflow.
        occ           = OW'(count_q) + OW'(inflight_q) - OW'(pop);

        if (rst) begin
            state_d = ST_RUN;
        end else if (redirect_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            if (redir_misalign) begin
                state_d = ST_FAULT;
`ifdef FETCH_MISALIGN_EN
                fault_pc_d = redirect_pc_i;
`endif
            end else begin
                state_d       = ST_RUN;
                re_o          = 1'b1;
                addr_o        = redir_tgt;
                pc_d          = redir_tgt + XLEN'(4);
                inflight_d    = 1'b1;
                inflight_pc_d = redir_tgt;
            end
        end else begin
            if (state_q == ST_RUN && occ < OW'(DEPTH)) begin
                re_o          = 1'b1;
                addr_o        = pc_q;
                pc_d          = pc_q + XLEN'(4);
                inflight_d    = 1'b1;
                inflight_pc_d = pc_q;
            end
            if (inflight_q) begin
                push = 1'b1;
            end
`ifdef FETCH_MISALIGN_EN
            if (state_q == ST_FAULT) begin
                push       = 1'b1;
                push_pc    = fault_pc_q;
                push_instr = XLEN'(32'h0000_0013);
                push_fault = 1'b1;
                state_d    = ST_HALT;
            end
`endif
            if (pop) begin
                head_d = head_q + PW'(1);
            end
            if (push) begin
                tail_d = tail_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_RUN;
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
        end
    end

    // Queue storage needs no reset: reads are gated by count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            q_pc_q[tail_q]    <= push_pc;
            q_instr_q[tail_q] <= push_instr;
        end
    end

    assign pc_o    = head_valid ? q_pc_q[head_q]    : '0;
    assign instr_o = head_valid ? q_instr_q[head_q] : '0;

`ifdef FETCH_MISALIGN_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            fault_pc_q <= '0;
        end else begin
            fault_pc_q <= fault_pc_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_fault_q[tail_q] <= push_fault;
        end
    end

    assign fault_o = head_valid ? q_fault_q[head_q] : 1'b0;
`endif

endmodule

// File: tb/tb_fetch_prefetch.sv
// Self-checking bench for fetch_prefetch: directed scenarios plus a randomized run against a PC-queue model.
module tb_fetch_prefetch;

    localparam logic [31:0] RST_PC = 32'h0000_0080;
    localparam int          DEPTH  = 4;

    logic        clk;
    logic        rst;
    logic        re_o;
    logic [31:0] addr_o;
    logic [31:0] instr_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
`ifdef FETCH_MISALIGN_EN
    logic        fault_o;
`endif
    logic [31:0] mem_rdata;

    int n_cmp = 0;
    int n_bad = 0;

    fetch_prefetch #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
        .clk           (clk),
        .rst           (rst),
        .re_o          (re_o),
        .addr_o        (addr_o),
        .instr_i       (instr_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .instr_valid_o (instr_valid_o),
        .instr_ready_i (instr_ready_i),
        .instr_o       (instr_o),
        .pc_o          (pc_o)
`ifdef FETCH_MISALIGN_EN
        ,
        .fault_o       (fault_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory image: data is a fixed scramble of the address, returned one cycle after the read.
    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_5A5A;
    endfunction

    always @(posedge clk) mem_rdata <= re_o ? mem_f(addr_o) : 32'hDEAD_BEEF;
    assign instr_i = mem_rdata;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        next_cycle();
        rst = 1'b1; redirect_i = 1'b0; instr_ready_i = 1'b0;
        next_cycle();
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        next_cycle();
        rst = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h0000_0400; instr_ready_i = 1'b1;
        next_cycle();
        @(negedge clk);
        n_cmp++; if (re_o !== 1'b0) begin n_bad++; $display("FAIL reset_re: got %0b want 0", re_o); end
        n_cmp++; if (addr_o !== 32'h0) begin n_bad++; $display("FAIL reset_addr: got %h want 0", addr_o); end
        n_cmp++; if (instr_valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %0b want 0", instr_valid_o); end
        n_cmp++; if (instr_o !== 32'h0) begin n_bad++; $display("FAIL reset_instr: got %h want 0", instr_o); end
        n_cmp++; if (pc_o !== 32'h0) begin n_bad++; $display("FAIL reset_pc: got %h want 0", pc_o); end
`ifdef FETCH_MISALIGN_EN
        n_cmp++; if (fault_o !== 1'b0) begin n_bad++; $display("FAIL reset_fault: got %0b want 0", fault_o); end
`endif
        next_cycle();
        rst = 1'b0; redirect_i = 1'b0;
        @(negedge clk);
        n_cmp++; if (re_o !== 1'b1 || addr_o !== RST_PC) begin
            n_bad++; $display("FAIL reset_first_issue: got re=%0b addr=%h want re=1 addr=%h", re_o, addr_o, RST_PC);
        end
        n_cmp++; if (instr_valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_first_valid: got %0b want 0", instr_valid_o); end
    endtask

    task automatic test_stream();
        logic [31:0] ep;
        do_reset();
        instr_ready_i = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            n_cmp++; if (re_o !== 1'b1 || addr_o !== RST_PC + 32'(4 * c)) begin
                n_bad++; $display("FAIL stream_issue c%0d: got re=%0b addr=%h want re=1 addr=%h", c, re_o, addr_o, RST_PC + 32'(4 * c));
            end
            if (c < 2) begin
                n_cmp++; if (instr_valid_o !== 1'b0) begin n_bad++; $display("FAIL stream_early_valid c%0d: got %0b want 0", c, instr_valid_o); end
            end else begin
                ep = RST_PC + 32'(4 * (c - 2));
                n_cmp++; if (instr_valid_o !== 1'b1 || pc_o !== ep || instr_o !== mem_f(ep)) begin
                    n_bad++; $display("FAIL stream_head c%0d: got v=%0b pc=%h ins=%h want v=1 pc=%h ins=%h", c, instr_valid_o, pc_o, instr_o, ep, mem_f(ep));
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_backpressure();
        int          reads;
        int          got;
        logic [31:0] ep;
        do_reset();
        instr_ready_i = 1'b0;
        reads = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (re_o === 1'b1) reads++;
            if (c >= 2) begin
                n_cmp++; if (instr_valid_o !== 1'b1 || pc_o !== RST_PC) begin
                    n_bad++; $display("FAIL bp_hold c%0d: got v=%0b pc=%h want v=1 pc=%h", c, instr_valid_o, pc_o, RST_PC);
                end
            end
            next_cycle();
        end
        n_cmp++; if (reads != DEPTH) begin n_bad++; $display("FAIL bp_reads: got %0d want %0d", reads, DEPTH); end
        @(negedge clk);
        n_cmp++; if (re_o !== 1'b0) begin n_bad++; $display("FAIL bp_full_re: got %0b want 0", re_o); end
        next_cycle();
        instr_ready_i = 1'b1;
        got = 0;
        ep  = RST_PC;
        for (int c = 0; c < 20 && got < 5; c++) begin
            @(negedge clk);
            if (c == 0) begin
                n_cmp++; if (re_o !== 1'b1 || addr_o !== RST_PC + 32'h10) begin
                    n_bad++; $display("FAIL bp_resume: got re=%0b addr=%h want re=1 addr=%h", re_o, addr_o, RST_PC + 32'h10);
                end
            end
            if (instr_valid_o === 1'b1) begin
                n_cmp++; if (pc_o !== ep || instr_o !== mem_f(ep)) begin
                    n_bad++; $display("FAIL bp_drain: got pc=%h ins=%h want pc=%h ins=%h", pc_o, instr_o, ep, mem_f(ep));
                end
                ep = ep + 32'h4;
                got++;
            end
            next_cycle();
        end
        n_cmp++; if (got != 5) begin n_bad++; $display("FAIL bp_drain_timeout: got %0d words want 5", got); end
    endtask

    task automatic test_redirect();
        logic [31:0] ep;
        do_reset();
        instr_ready_i = 1'b0;
        repeat (4) next_cycle();
        redirect_i = 1'b1; redirect_pc_i = 32'h0000_0100;
        @(negedge clk);
        n_cmp++; if (instr_valid_o !== 1'b0 || re_o !== 1'b1 || addr_o !== 32'h100) begin
            n_bad++; $display("FAIL redir_cycle: got v=%0b re=%0b addr=%h want v=0 re=1 addr=00000100", instr_valid_o, re_o, addr_o);
        end
        next_cycle();
        redirect_i = 1'b0; instr_ready_i = 1'b1;
        @(negedge clk);
        n_cmp++; if (instr_valid_o !== 1'b0 || addr_o !== 32'h104) begin
            n_bad++; $display("FAIL redir_gap: got v=%0b addr=%h want v=0 addr=00000104", instr_valid_o, addr_o);
        end
        ep = 32'h100;
        for (int c = 0; c < 5; c++) begin
            next_cycle();
            @(negedge clk);
            n_cmp++; if (instr_valid_o !== 1'b1 || pc_o !== ep || instr_o !== mem_f(ep)) begin
                n_bad++; $display("FAIL redir_stream c%0d: got v=%0b pc=%h ins=%h want v=1 pc=%h", c, instr_valid_o, pc_o, instr_o, ep);
            end
            ep = ep + 32'h4;
        end
    endtask

    task automatic test_redirect_pop_rst();
        do_reset();
        instr_ready_i = 1'b1;
        repeat (3) next_cycle();
        redirect_i = 1'b1; redirect_pc_i = 32'h0000_0200;
        @(negedge clk);
        n_cmp++; if (instr_valid_o !== 1'b0 || addr_o !== 32'h200) begin
            n_bad++; $display("FAIL redir_pop: got v=%0b addr=%h want v=0 addr=00000200", instr_valid_o, addr_o);
        end
        next_cycle();
        redirect_i = 1'b0;
        next_cycle();
        @(negedge clk);
        n_cmp++; if (instr_valid_o !== 1'b1 || pc_o !== 32'h200) begin
            n_bad++; $display("FAIL redir_pop_head: got v=%0b pc=%h want v=1 pc=00000200", instr_valid_o, pc_o);
        end
        next_cycle();
        rst = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h0000_0300;
        @(negedge clk);
        n_cmp++; if (re_o !== 1'b0 || instr_valid_o !== 1'b0) begin
            n_bad++; $display("FAIL rst_over_redir: got re=%0b v=%0b want re=0 v=0", re_o, instr_valid_o);
        end
        next_cycle();
        rst = 1'b0; redirect_i = 1'b0;
        @(negedge clk);
        n_cmp++; if (re_o !== 1'b1 || addr_o !== RST_PC) begin
            n_bad++; $display("FAIL rst_restart: got re=%0b addr=%h want re=1 addr=%h", re_o, addr_o, RST_PC);
        end
        next_cycle();
        next_cycle();
        @(negedge clk);
        n_cmp++; if (instr_valid_o !== 1'b1 || pc_o !== RST_PC) begin
            n_bad++; $display("FAIL rst_restart_head: got v=%0b pc=%h want v=1 pc=%h", instr_valid_o, pc_o, RST_PC);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] ea [5];
        ea = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004, 32'h0000_0008};
        do_reset();
        instr_ready_i = 1'b1;
        redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFF8;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_cmp++; if (re_o !== 1'b1 || addr_o !== ea[c]) begin
                n_bad++; $display("FAIL wrap_addr c%0d: got re=%0b addr=%h want re=1 addr=%h", c, re_o, addr_o, ea[c]);
            end
            if (c >= 2) begin
                n_cmp++; if (instr_valid_o !== 1'b1 || pc_o !== ea[c-2]) begin
                    n_bad++; $display("FAIL wrap_head c%0d: got v=%0b pc=%h want v=1 pc=%h", c, instr_valid_o, pc_o, ea[c-2]);
                end
            end
            next_cycle();
            redirect_i = 1'b0;
        end
    endtask

    // Model: queue of PCs issued and not yet accepted; the newest is in flight if it was issued last cycle.
    task automatic test_random();
        logic [31:0] exp_q [$];
        logic [31:0] exp_next;
        logic [31:0] t;
        logic [31:0] tgt;
        logic        last_issue;
        logic        exp_valid;
        logic        exp_re;
        logic        pop;
        logic        redir;
        int          sz;
        do_reset();
        exp_next   = RST_PC;
        last_issue = 1'b0;
        for (int c = 0; c < 800; c++) begin
            instr_ready_i = ($urandom_range(0, 9) < 6);
            redir = ($urandom_range(0, 11) == 0);
            t = $urandom();
            if ($urandom_range(0, 3) == 0) t = 32'hFFFF_FFE0 | (t & 32'h1F);
`ifdef FETCH_MISALIGN_EN
            t = t & ~32'h3;
`endif
            tgt = t & ~32'h3;
            redirect_i = redir; redirect_pc_i = t;
            @(negedge clk);
            sz = exp_q.size();
            exp_valid = (sz - int'(last_issue)) > 0 && !redir;
            n_cmp++; if (instr_valid_o !== exp_valid) begin
                n_bad++; $display("FAIL rnd_valid c%0d: got %0b want %0b", c, instr_valid_o, exp_valid);
            end
            if (redir) begin
                n_cmp++; if (re_o !== 1'b1 || addr_o !== tgt) begin
                    n_bad++; $display("FAIL rnd_redir c%0d: got re=%0b addr=%h want re=1 addr=%h", c, re_o, addr_o, tgt);
                end
                exp_q.delete();
                exp_q.push_back(tgt);
                exp_next   = tgt + 32'h4;
                last_issue = 1'b1;
            end else begin
                pop = exp_valid && instr_ready_i;
                if (pop) begin
                    n_cmp++; if (pc_o !== exp_q[0] || instr_o !== mem_f(exp_q[0])) begin
                        n_bad++; $display("FAIL rnd_head c%0d: got pc=%h ins=%h want pc=%h ins=%h", c, pc_o, instr_o, exp_q[0], mem_f(exp_q[0]));
                    end
                    void'(exp_q.pop_front());
                end
                exp_re = (sz - int'(pop)) < DEPTH;
                n_cmp++; if (re_o !== exp_re || (exp_re && addr_o !== exp_next)) begin
                    n_bad++; $display("FAIL rnd_issue c%0d: got re=%0b addr=%h want re=%0b addr=%h", c, re_o, addr_o, exp_re, exp_next);
                end
                if (exp_re) begin
                    exp_q.push_back(exp_next);
                    exp_next = exp_next + 32'h4;
                end
                last_issue = exp_re;
            end
            next_cycle();
        end
        redirect_i = 1'b0;
    endtask

`ifdef FETCH_MISALIGN_EN
    task automatic test_misalign();
        do_reset();
        instr_ready_i = 1'b1;
        repeat (3) next_cycle();
        redirect_i = 1'b1; redirect_pc_i = 32'h0000_0102;
        @(negedge clk);
        n_cmp++; if (re_o !== 1'b0 || instr_valid_o !== 1'b0) begin
            n_bad++; $display("FAIL mis_redir: got re=%0b v=%0b want re=0 v=0", re_o, instr_valid_o);
        end
        next_cycle();
        redirect_i = 1'b0;
        @(negedge clk);
        n_cmp++; if (re_o !== 1'b0 || instr_valid_o !== 1'b0) begin
            n_bad++; $display("FAIL mis_gap: got re=%0b v=%0b want re=0 v=0", re_o, instr_valid_o);
        end
        next_cycle();
        @(negedge clk);
        n_cmp++; if (instr_valid_o !== 1'b1 || pc_o !== 32'h102 || instr_o !== 32'h13 || fault_o !== 1'b1) begin
            n_bad++; $display("FAIL mis_entry: got v=%0b pc=%h ins=%h f=%0b want v=1 pc=00000102 ins=00000013 f=1", instr_valid_o, pc_o, instr_o, fault_o);
        end
        for (int c = 0; c < 4; c++) begin
            next_cycle();
            @(negedge clk);
            n_cmp++; if (re_o !== 1'b0 || instr_valid_o !== 1'b0) begin
                n_bad++; $display("FAIL mis_halt c%0d: got re=%0b v=%0b want re=0 v=0", c, re_o, instr_valid_o);
            end
        end
        next_cycle();
        redirect_i = 1'b1; redirect_pc_i = 32'h0000_0200;
        @(negedge clk);
        n_cmp++; if (re_o !== 1'b1 || addr_o !== 32'h200) begin
            n_bad++; $display("FAIL mis_resume: got re=%0b addr=%h want re=1 addr=00000200", re_o, addr_o);
        end
        next_cycle();
        redirect_i = 1'b0;
        next_cycle();
        @(negedge clk);
        n_cmp++; if (instr_valid_o !== 1'b1 || pc_o !== 32'h200 || fault_o !== 1'b0) begin
            n_bad++; $display("FAIL mis_resume_head: got v=%0b pc=%h f=%0b want v=1 pc=00000200 f=0", instr_valid_o, pc_o, fault_o);
        end
    endtask
`endif

    initial begin
        rst = 1'b1; redirect_i = 1'b0; redirect_pc_i = 32'h0; instr_ready_i = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_redirect_pop_rst();
        test_wrap();
        test_random();
`ifdef FETCH_MISALIGN_EN
        test_misalign();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

endmodule
